// File: rtl/csr_trap_seq.sv
// csr_trap_seq: sequencer that runs CSR ops, trap entry and MRET on the CSR file's port pair.
// At most one CSR port is active in any state; the CSR file forwards write data on matching addresses.
module csr_trap_seq #(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] ILL_CAUSE   = 32'd2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_inst_valid,
  output logic        o_inst_ready,
  input  logic [2:0]  i_inst_op,
  input  logic [31:0] i_inst_pc,
  input  logic [11:0] i_inst_csr,
  input  logic [31:0] i_inst_src,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data,
  output logic        o_redir_valid,
  output logic [31:0] o_redir_pc,
  output logic        o_csr_ren,
  output logic [11:0] o_csr_raddr,
  input  logic [31:0] i_csr_rdata,
  output logic        o_csr_wen,
  output logic [11:0] o_csr_waddr,
  output logic [31:0] o_csr_wdata,
  output logic        o_busy
);
  typedef enum logic [3:0] {
    IDLE, C_RD, C_WR, T_EPC, T_CAUSE, T_SRD, T_SWR, T_VEC, M_SRD, M_SWR, M_EPC, DONE
  } state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_pc, r_src, r_old, r_st, r_cause, r_npc;
  logic [11:0] r_csr;
  logic        r_redir;
  logic        w_csr_op, w_ro_wr, w_trap, w_skip;
  logic [31:0] w_new, w_st_trap, w_st_mret;
  assign w_csr_op = i_inst_op <= 3'd2;
  // Writing a read-only CSR traps; RS/RC with src==0 is a pure read and stays legal.
  assign w_ro_wr  = w_csr_op && i_inst_csr[11:10] == 2'b11 && (i_inst_op == 3'd0 || i_inst_src != 32'd0);
  assign w_trap   = (!w_csr_op && i_inst_op != 3'd4) || w_ro_wr;
  assign w_skip   = r_op != 3'd0 && r_src == 32'd0;
  assign w_new    = r_op == 3'd0 ? r_src : r_op == 3'd1 ? (r_old | r_src) : (r_old & ~r_src);
  assign w_st_trap = {r_st[31:13], 2'b11, r_st[10:8], r_st[3], r_st[6:4], 1'b0, r_st[2:0]};
  assign w_st_mret = {r_st[31:13], 2'b11, r_st[10:8], 1'b1, r_st[6:4], r_st[7], r_st[2:0]};
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = !i_inst_valid ? IDLE : i_inst_op == 3'd4 ? M_SRD : w_trap ? T_EPC : C_RD;
      C_RD:    w_next = C_WR;
      C_WR:    w_next = DONE;
      T_EPC:   w_next = T_CAUSE;
      T_CAUSE: w_next = T_SRD;
      T_SRD:   w_next = T_SWR;
      T_SWR:   w_next = T_VEC;
      T_VEC:   w_next = DONE;
      M_SRD:   w_next = M_SWR;
      M_SWR:   w_next = M_EPC;
      M_EPC:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op    <= '0;
      r_pc    <= '0;
      r_csr   <= '0;
      r_src   <= '0;
      r_cause <= '0;
      r_redir <= 1'b0;
      r_old   <= '0;
      r_st    <= '0;
      r_npc   <= '0;
    end else begin
      if (r_state == IDLE && i_inst_valid) begin
        r_op    <= i_inst_op;
        r_pc    <= i_inst_pc;
        r_csr   <= i_inst_csr;
        r_src   <= i_inst_src;
        r_cause <= i_inst_op == 3'd3 ? ECALL_CAUSE : ILL_CAUSE;
        r_redir <= !w_csr_op || w_ro_wr;
      end
      if (r_state == C_RD) r_old <= i_csr_rdata;
      if (r_state == T_SRD || r_state == M_SRD) r_st <= i_csr_rdata;
      if (r_state == T_VEC || r_state == M_EPC) r_npc <= i_csr_rdata & ~32'h3;
    end
  end
  always_comb begin
    o_inst_ready  = r_state == IDLE;
    o_busy        = r_state != IDLE;
    o_csr_ren     = r_state == C_RD || r_state == T_SRD || r_state == T_VEC || r_state == M_SRD || r_state == M_EPC;
    o_csr_raddr   = r_state == C_RD ? r_csr :
                    (r_state == T_SRD || r_state == M_SRD) ? 12'h300 :
                    r_state == T_VEC ? 12'h305 :
                    r_state == M_EPC ? 12'h341 : 12'h000;
    o_csr_wen     = !reset && ((r_state == C_WR && !w_skip) || r_state == T_EPC || r_state == T_CAUSE ||
                    r_state == T_SWR || r_state == M_SWR);
    o_csr_waddr   = r_state == C_WR ? r_csr :
                    r_state == T_EPC ? 12'h341 :
                    r_state == T_CAUSE ? 12'h342 :
                    (r_state == T_SWR || r_state == M_SWR) ? 12'h300 : 12'h000;
    o_csr_wdata   = r_state == C_WR ? w_new :
                    r_state == T_EPC ? (r_pc & ~32'h3) :
                    r_state == T_CAUSE ? r_cause :
                    r_state == T_SWR ? w_st_trap :
                    r_state == M_SWR ? w_st_mret : 32'd0;
    o_rd_valid    = r_state == DONE && !r_redir;
    o_rd_data     = o_rd_valid ? r_old : 32'd0;
    o_redir_valid = r_state == DONE && r_redir;
    o_redir_pc    = o_redir_valid ? r_npc : 32'd0;
  end
endmodule

// File: tb/tb_csr_trap_seq.sv
// tb_csr_trap_seq: vector table driven into csr_trap_seq against a small CSR file model,
// with result and write scoreboards checked as the DUT produces them.
module tb_csr_trap_seq;
  logic        clock = 1'b0, reset = 1'b1;
  logic        i_inst_valid = 1'b0;
  logic [2:0]  i_inst_op = '0;
  logic [31:0] i_inst_pc = '0, i_inst_src = '0;
  logic [11:0] i_inst_csr = '0;
  logic        o_inst_ready, o_rd_valid, o_redir_valid, o_csr_ren, o_csr_wen, o_busy;
  logic [31:0] o_rd_data, o_redir_pc, i_csr_rdata, o_csr_wdata;
  logic [11:0] o_csr_raddr, o_csr_waddr;

  csr_trap_seq dut (
    .clock(clock), .reset(reset), .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
    .i_inst_op(i_inst_op), .i_inst_pc(i_inst_pc), .i_inst_csr(i_inst_csr), .i_inst_src(i_inst_src),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_redir_valid(o_redir_valid), .o_redir_pc(o_redir_pc),
    .o_csr_ren(o_csr_ren), .o_csr_raddr(o_csr_raddr), .i_csr_rdata(i_csr_rdata), .o_csr_wen(o_csr_wen),
    .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata), .o_busy(o_busy)
  );

  always #5 clock = ~clock;

  // CSR file model: four writable registers plus the two read-only IDs
  logic        pre_en = 1'b0;
  logic [31:0] pre_st = '0, pre_tv = '0, pre_ep = '0;
  logic [31:0] m_st = '0, m_tv = '0, m_ep = '0, m_ca = '0;
  int          cyc = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (pre_en) begin
      m_st <= pre_st;
      m_tv <= pre_tv;
      m_ep <= pre_ep;
    end else if (o_csr_wen) begin
      if (o_csr_waddr == 12'h300) m_st <= o_csr_wdata;
      if (o_csr_waddr == 12'h305) m_tv <= o_csr_wdata;
      if (o_csr_waddr == 12'h341) m_ep <= o_csr_wdata;
      if (o_csr_waddr == 12'h342) m_ca <= o_csr_wdata;
    end
  end
  always_comb begin
    i_csr_rdata = 32'd0;
    case (o_csr_raddr)
      12'h300: i_csr_rdata = m_st;
      12'h305: i_csr_rdata = m_tv;
      12'h341: i_csr_rdata = m_ep;
      12'h342: i_csr_rdata = m_ca;
      12'hF12: i_csr_rdata = 32'h017E1A6F;
      default: i_csr_rdata = 32'd0;
    endcase
  end

  typedef struct {
    logic [2:0] op; logic [31:0] pc; logic [11:0] csr; logic [31:0] src;
    logic [31:0] mst, mtv, mep;
    logic redir; logic [31:0] exp; int lat; int nr; int nw;
    logic [0:2][11:0] wa; logic [0:2][31:0] wd;
  } vec_t;
  typedef struct { logic redir; logic [31:0] data; int lat; int nr; } exp_t;

  exp_t        sbq[$];
  logic [43:0] wq[$];
  vec_t        v[10];
  int          checks = 0, errors = 0, acc_cyc = 0, rcnt = 0;
  logic        accepted = 1'b0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  task automatic mon();
    exp_t e;
    logic [43:0] w;
    chk("ren_wen_overlap", 64'(o_csr_ren & o_csr_wen), 64'd0);
    chk("rd_redir_both", 64'(o_rd_valid & o_redir_valid), 64'd0);
    if (o_csr_wen) begin
      if (wq.size() == 0) chk("unexpected_write", 64'({o_csr_waddr, o_csr_wdata}), 64'd0);
      else begin
        w = wq.pop_front();
        chk("csr_write", 64'({o_csr_waddr, o_csr_wdata}), 64'(w));
      end
    end
    if (o_csr_ren) rcnt++;
    if (i_inst_valid && o_inst_ready) begin
      acc_cyc = cyc;
      accepted = 1'b1;
    end
    if (o_rd_valid || o_redir_valid) begin
      if (sbq.size() == 0) chk("unexpected_result", 64'({o_redir_valid, o_rd_valid}), 64'd0);
      else begin
        e = sbq.pop_front();
        chk("result_kind", 64'(o_redir_valid), 64'(e.redir));
        chk("result_data", 64'(e.redir ? o_redir_pc : o_rd_data), 64'(e.data));
        chk("result_latency", 64'(cyc - acc_cyc), 64'(e.lat));
        chk("read_count", 64'(rcnt), 64'(e.nr));
      end
      rcnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    mon();
    @(posedge clock);
    #1;
  endtask

  task automatic preset(input logic [31:0] st, input logic [31:0] tv, input logic [31:0] ep);
    pre_en = 1'b1; pre_st = st; pre_tv = tv; pre_ep = ep;
    @(posedge clock);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [11:0] csr, input logic [31:0] src);
    i_inst_op = op; i_inst_pc = pc; i_inst_csr = csr; i_inst_src = src;
    accepted = 1'b0;
    i_inst_valid = 1'b1;
    for (int k = 0; k < 20 && !accepted; k++) tick();
    i_inst_valid = 1'b0;
    i_inst_op = 3'd7; i_inst_csr = 12'hFFF; i_inst_src = 32'hFFFF_FFFF;
    if (!accepted) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input vec_t t);
    preset(t.mst, t.mtv, t.mep);
    for (int i = 0; i < t.nw; i++) wq.push_back({t.wa[i], t.wd[i]});
    sbq.push_back('{t.redir, t.exp, t.lat, t.nr});
    issue(t.op, t.pc, t.csr, t.src);
    for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
    chk("result_pending", 64'(sbq.size()), 64'd0);
    chk("writes_pending", 64'(wq.size()), 64'd0);
    sbq.delete();
    wq.delete();
    rcnt = 0;
  endtask

  initial begin
    v[0] = '{3'd0, 32'h0, 12'h305, 32'h80000100, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 3, 1, 1,
             {12'h305, 12'h0, 12'h0}, {32'h80000100, 32'h0, 32'h0}};
    v[1] = '{3'd1, 32'h0, 12'h300, 32'h0, 32'h1800, 32'h0, 32'h0, 1'b0, 32'h1800, 3, 1, 0,
             {12'h0, 12'h0, 12'h0}, {32'h0, 32'h0, 32'h0}};
    v[2] = '{3'd2, 32'h0, 12'h300, 32'h1000, 32'h1800, 32'h0, 32'h0, 1'b0, 32'h1800, 3, 1, 1,
             {12'h300, 12'h0, 12'h0}, {32'h0800, 32'h0, 32'h0}};
    v[3] = '{3'd3, 32'h80000010, 12'h0, 32'h0, 32'h1808, 32'h80000101, 32'h0, 1'b1, 32'h80000100, 6, 2, 3,
             {12'h341, 12'h342, 12'h300}, {32'h80000010, 32'd11, 32'h1880}};
    v[4] = '{3'd4, 32'h0, 12'h0, 32'h0, 32'h1880, 32'h0, 32'h80000014, 1'b1, 32'h80000014, 4, 2, 1,
             {12'h300, 12'h0, 12'h0}, {32'h1888, 32'h0, 32'h0}};
    v[5] = '{3'd0, 32'h80000020, 12'hF11, 32'h5, 32'h0008, 32'h200, 32'h0, 1'b1, 32'h200, 6, 2, 3,
             {12'h341, 12'h342, 12'h300}, {32'h80000020, 32'd2, 32'h1880}};
    v[6] = '{3'd6, 32'h80000033, 12'h0, 32'h0, 32'h0, 32'h80000004, 32'h0, 1'b1, 32'h80000004, 6, 2, 3,
             {12'h341, 12'h342, 12'h300}, {32'h80000030, 32'd2, 32'h1800}};
    v[7] = '{3'd1, 32'h0, 12'hF12, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h017E1A6F, 3, 1, 0,
             {12'h0, 12'h0, 12'h0}, {32'h0, 32'h0, 32'h0}};
    v[8] = '{3'd1, 32'h0, 12'h123, 32'h5, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 3, 1, 1,
             {12'h123, 12'h0, 12'h0}, {32'h5, 32'h0, 32'h0}};
    v[9] = '{3'd2, 32'h44, 12'hF11, 32'h1, 32'h1888, 32'h100, 32'h0, 1'b1, 32'h100, 6, 2, 3,
             {12'h341, 12'h342, 12'h300}, {32'h44, 32'd2, 32'h1880}};
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_ready", 64'(o_inst_ready), 64'd1);
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_outputs", 64'({o_rd_valid, o_redir_valid, o_csr_ren, o_csr_wen}), 64'd0);
    chk("reset_data", 64'({o_rd_data, o_redir_pc}), 64'd0);
    for (int i = 0; i < 10; i++) run(v[i]);
    // reset while the mcause write is on the port: the write must be suppressed
    preset(32'h1808, 32'h80000101, 32'h0);
    wq.push_back({12'h341, 32'h80000010});
    issue(3'd3, 32'h80000010, 12'h0, 32'h0);
    tick();
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_wen", 64'(o_csr_wen), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_mid_ready", 64'(o_inst_ready), 64'd1);
    chk("rst_mid_valids", 64'({o_rd_valid, o_redir_valid, o_busy}), 64'd0);
    chk("rst_mid_epc_written", 64'(wq.size()), 64'd0);
    chk("rst_mid_cause_kept", 64'(m_ca), 64'd2);
    wq.delete();
    rcnt = 0;
    run(v[1]);
    run(v[4]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
